// File: rtl/min_select_seq.sv
// Sequential N-way minimum selector: captures N (energy, direction) candidates
// with a valid mask on start, scans one per cycle, reports the minimum.
//
// Ports:
//   m_clock, p_reset     clock, synchronous active-high reset
//   start                begin a selection (accepted in IDLE only)
//   in_ene / in_plot     packed candidate energies / direction codes
//   in_valid             per-candidate eligibility mask
//   busy                 high while scanning or finishing
//   done                 one-cycle result pulse
//   found                at least one eligible candidate existed
//   outene/outplot/outidx  winner energy, direction code, index
module min_select_seq #(
  parameter int N  = 4,
  parameter int EW = 10,
  parameter int PW = 10,
  localparam int IW = (N > 2) ? $clog2(N) : 1
) (
  input  logic            m_clock,
  input  logic            p_reset,
  input  logic            start,
  input  logic [N*EW-1:0] in_ene,
  input  logic [N*PW-1:0] in_plot,
  input  logic [N-1:0]    in_valid,
  output logic            busy,
  output logic            done,
  output logic            found,
  output logic [EW-1:0]   outene,
  output logic [PW-1:0]   outplot,
  output logic [IW-1:0]   outidx
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FIN
  } state_t;

  state_t state, state_nxt;

  logic [IW-1:0] cnt;
  logic [EW-1:0] ene_r  [N];
  logic [PW-1:0] plot_r [N];
  logic [N-1:0]  valid_r;

  logic [EW-1:0] best_ene;
  logic [PW-1:0] best_plot;
  logic [IW-1:0] best_idx;
  logic          best_found;

  logic take;
  logic last;

  // <= makes ties go to the later (higher-index) candidate.
  always_comb begin
    take = 1'b0;
    last = (cnt == IW'(N - 1));
    if (valid_r[cnt]) begin
      take = !best_found || (ene_r[cnt] <= best_ene);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = SCAN;
      SCAN: if (last) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge m_clock) begin
    if (p_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      cnt        <= '0;
      valid_r    <= '0;
      best_ene   <= '0;
      best_plot  <= '0;
      best_idx   <= '0;
      best_found <= 1'b0;
      done       <= 1'b0;
      found      <= 1'b0;
      outene     <= '0;
      outplot    <= '0;
      outidx     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < N; k++) begin
              ene_r[k]  <= in_ene[k*EW +: EW];
              plot_r[k] <= in_plot[k*PW +: PW];
            end
            valid_r    <= in_valid;
            cnt        <= '0;
            best_ene   <= '0;
            best_plot  <= '0;
            best_idx   <= '0;
            best_found <= 1'b0;
            found      <= 1'b0;
            outene     <= '0;
            outplot    <= '0;
            outidx     <= '0;
          end
        end
        SCAN: begin
          if (take) begin
            best_found <= 1'b1;
            best_ene   <= ene_r[cnt];
            best_plot  <= plot_r[cnt];
            best_idx   <= cnt;
          end
          cnt <= last ? '0 : cnt + IW'(1);
        end
        FIN: begin
          done    <= 1'b1;
          found   <= best_found;
          outene  <= best_ene;
          outplot <= best_plot;
          outidx  <= best_idx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_min_select_seq.sv
// Self-checking bench for min_select_seq: directed cases from the
// datasheet plus randomized selections against a reference model.
module tb_min_select_seq;

  localparam int N  = 4;
  localparam int EW = 10;
  localparam int PW = 10;
  localparam int IW = 2;

  logic            m_clock = 0;
  logic            p_reset = 1;
  logic            start = 0;
  logic [N*EW-1:0] in_ene = '0;
  logic [N*PW-1:0] in_plot = '0;
  logic [N-1:0]    in_valid = '0;
  logic            busy;
  logic            done;
  logic            found;
  logic [EW-1:0]   outene;
  logic [PW-1:0]   outplot;
  logic [IW-1:0]   outidx;

  int checks = 0;
  int fails  = 0;

  logic [EW-1:0] c_ene  [N];
  logic [PW-1:0] c_plot [N];
  logic [N-1:0]  c_valid;

  min_select_seq #(.N(N), .EW(EW), .PW(PW)) dut (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .start   (start),
    .in_ene  (in_ene),
    .in_plot (in_plot),
    .in_valid(in_valid),
    .busy    (busy),
    .done    (done),
    .found   (found),
    .outene  (outene),
    .outplot (outplot),
    .outidx  (outidx)
  );

  always #5 m_clock = ~m_clock;

  task automatic apply();
    for (int k = 0; k < N; k++) begin
      in_ene[k*EW +: EW]  = c_ene[k];
      in_plot[k*PW +: PW] = c_plot[k];
    end
    in_valid = c_valid;
  endtask

  // Reference: smallest energy among eligible; among equals, the last index.
  task automatic model(output logic ef, output logic [EW-1:0] ee,
                       output logic [PW-1:0] ep, output logic [IW-1:0] ei);
    int m;
    ef = 0; ee = 0; ep = 0; ei = 0;
    m = 1 << EW;
    for (int k = 0; k < N; k++)
      if (c_valid[k] && int'(c_ene[k]) < m) m = int'(c_ene[k]);
    for (int k = 0; k < N; k++)
      if (c_valid[k] && int'(c_ene[k]) == m) begin
        ef = 1; ee = c_ene[k]; ep = c_plot[k]; ei = IW'(k);
      end
  endtask

  task automatic set4(input int e0, e1, e2, e3, input logic [N-1:0] v);
    c_ene[0] = EW'(e0); c_ene[1] = EW'(e1);
    c_ene[2] = EW'(e2); c_ene[3] = EW'(e3);
    c_valid = v;
  endtask

  task automatic rand_cands();
    for (int k = 0; k < N; k++) begin
      c_ene[k]  = ($urandom_range(0, 3) == 0) ?
                  EW'($urandom_range(0, 3)) : EW'($urandom);
      c_plot[k] = PW'($urandom);
    end
    c_valid = N'($urandom);
  endtask

  // Start a selection, check latency, busy length, result and hold.
  task automatic run(input string nm, input bit scramble);
    logic ef; logic [EW-1:0] ee; logic [PW-1:0] ep; logic [IW-1:0] ei;
    int lat, bcnt;
    model(ef, ee, ep, ei);
    @(negedge m_clock);
    apply();
    start = 1;
    @(posedge m_clock);
    #1 start = 0;
    lat = -1; bcnt = 0;
    for (int i = 0; i <= N + 5 && lat < 0; i++) begin
      if (i > 0) begin
        @(posedge m_clock);
        #1;
      end
      if (scramble) begin
        in_ene = {$urandom, $urandom};
        in_valid = N'($urandom);
      end
      if (busy) bcnt++;
      if (done) lat = i;
    end
    checks++;
    if (lat !== N + 1) begin
      fails++;
      $display("FAIL %s latency got=%0d want=%0d", nm, lat, N + 1);
    end
    checks++;
    if (bcnt !== N + 1) begin
      fails++;
      $display("FAIL %s busy_cycles got=%0d want=%0d", nm, bcnt, N + 1);
    end
    checks++;
    if ({found, outene, outplot, outidx} !== {ef, ee, ep, ei}) begin
      fails++;
      $display("FAIL %s result got f=%0d e=%0d p=%0d i=%0d want f=%0d e=%0d p=%0d i=%0d",
               nm, found, outene, outplot, outidx, ef, ee, ep, ei);
    end
    @(posedge m_clock);
    @(posedge m_clock);
    #1;
    checks++;
    if ({done, busy, found, outene, outplot, outidx} !== {2'b00, ef, ee, ep, ei}) begin
      fails++;
      $display("FAIL %s hold got d=%0d b=%0d f=%0d e=%0d i=%0d want d=0 b=0 f=%0d e=%0d i=%0d",
               nm, done, busy, found, outene, outidx, ef, ee, ei);
    end
  endtask

  task automatic test_reset();
    p_reset = 1;
    start = 1;
    repeat (3) @(posedge m_clock);
    #1;
    checks++;
    if ({busy, done, found, outene, outplot, outidx} !== '0) begin
      fails++;
      $display("FAIL reset outputs got b=%0d d=%0d f=%0d e=%0d p=%0d i=%0d want all 0",
               busy, done, found, outene, outplot, outidx);
    end
    start = 0;
    p_reset = 0;
  endtask

  task automatic test_basic();
    set4(40, 12, 30, 25, 4'b1111);
    c_plot[0] = 1; c_plot[1] = 2; c_plot[2] = 4; c_plot[3] = 8;
    run("basic", 0);
    checks++;
    if ({outene, outplot, outidx} !== {EW'(12), PW'(2), IW'(1)}) begin
      fails++;
      $display("FAIL basic_const got e=%0d p=%0d i=%0d want 12 2 1",
               outene, outplot, outidx);
    end
  endtask

  task automatic test_mask_tie();
    set4(5, 9, 9, 3, 4'b0111);
    run("mask", 0);
    checks++;
    if ({outene, outidx} !== {EW'(5), IW'(0)}) begin
      fails++;
      $display("FAIL mask_const got e=%0d i=%0d want 5 0", outene, outidx);
    end
    set4(7, 9, 7, 9, 4'b1111);
    run("tie", 0);
    checks++;
    if (outidx !== IW'(2)) begin
      fails++;
      $display("FAIL tie_const got i=%0d want 2", outidx);
    end
  endtask

  task automatic test_all_blocked();
    rand_cands();
    c_valid = '0;
    run("blocked", 0);
    checks++;
    if ({found, outene, outplot, outidx} !== '0) begin
      fails++;
      $display("FAIL blocked_const got f=%0d e=%0d want 0 0", found, outene);
    end
  endtask

  task automatic test_extremes();
    set4(1023, 1023, 1023, 1023, 4'b0100);
    run("extreme", 0);
    checks++;
    if ({found, outene, outidx} !== {1'b1, EW'(1023), IW'(2)}) begin
      fails++;
      $display("FAIL extreme_const got f=%0d e=%0d i=%0d want 1 1023 2",
               found, outene, outidx);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      rand_cands();
      run("random", 0);
    end
  endtask

  task automatic test_scramble();
    for (int t = 0; t < 10; t++) begin
      rand_cands();
      run("scramble", 1);
    end
  endtask

  task automatic test_held_start();
    int cnt, prev, bad;
    rand_cands();
    @(negedge m_clock);
    apply();
    start = 1;
    @(posedge m_clock);
    cnt = 0; prev = -1; bad = 0;
    for (int i = 1; i <= 3 * (N + 2); i++) begin
      @(posedge m_clock);
      #1;
      if (done) begin
        cnt++;
        if (prev >= 0 && i - prev != N + 2) bad++;
        if (prev < 0 && i != N + 1) bad++;
        prev = i;
      end
    end
    start = 0;
    checks++;
    if (cnt !== 3 || bad !== 0) begin
      fails++;
      $display("FAIL held_start got pulses=%0d bad_gaps=%0d want 3 0", cnt, bad);
    end
    repeat (N + 3) @(posedge m_clock);
  endtask

  task automatic test_reset_mid_scan();
    int dcnt;
    set4(100, 50, 20, 60, 4'b1111);
    @(negedge m_clock);
    apply();
    start = 1;
    @(posedge m_clock);
    #1 start = 0;
    @(posedge m_clock);
    @(posedge m_clock);
    #1 p_reset = 1;
    @(posedge m_clock);
    #1 p_reset = 0;
    checks++;
    if ({busy, done, found, outene, outplot, outidx} !== '0) begin
      fails++;
      $display("FAIL mid_reset got b=%0d d=%0d f=%0d e=%0d want all 0",
               busy, done, found, outene);
    end
    dcnt = 0;
    for (int i = 0; i < N + 4; i++) begin
      @(posedge m_clock);
      #1;
      if (done || busy) dcnt++;
    end
    checks++;
    if (dcnt !== 0) begin
      fails++;
      $display("FAIL mid_reset_quiet got active=%0d want 0", dcnt);
    end
    rand_cands();
    run("after_reset", 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mask_tie();
    test_all_blocked();
    test_extremes();
    test_random();
    test_scramble();
    test_held_start();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/min_select_seq.md
# min_select_seq

Sequential N-way minimum selector for the maze-search datapath. Captures N candidate (energy, direction) pairs with a per-candidate valid mask on a start pulse, scans them one per cycle, and reports the minimum-energy candidate's energy, direction code and index with a one-cycle done pulse. It generalises the two-input combinational min/direction selector to N candidates, adds masking of blocked neighbours (walls/visited cells), and replaces the combinational enable with a start/busy/done handshake.

## Interface
- N, 4: number of candidates, 2..16.
- EW, 10: energy width in bits.
- PW, 10: direction/plot code width in bits.
- IW, derived as max(1, ceil(log2 N)): index width. Not overridable.

- m_clock  in  1  clock; all state updates on the rising edge.
- p_reset  in  1  reset; synchronous and active-high.
- start  in  1  begin a selection; accepted only in IDLE.
- in_ene  in  N*EW  candidate energies; candidate k occupies bits [k*EW +: EW].
- in_plot  in  N*PW  candidate direction codes; candidate k occupies bits [k*PW +: PW].
- in_valid  in  N  bit k = 1 means candidate k is eligible.
- busy  out  1  high in SCAN and DONE.
- done  out  1  one-cycle pulse; result outputs are valid from this cycle.
- found  out  1  1 if at least one eligible candidate existed.
- outene  out  EW  minimum energy, or 0 if found = 0.
- outplot  out  PW  direction code of the winner, or 0 if found = 0.
- outidx  out  IW  index of the winner, or 0 if found = 0.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE + start = 1:
  - Register in_ene, in_plot and in_valid.
  - Clear the running-best registers and the found flag.
  - Set the scan counter to 0 and go to SCAN.
  - Inputs may change after this cycle without affecting the result.
- IDLE + start = 0: stay in IDLE. Outputs hold their previous result.
- SCAN, one candidate per cycle at counter k. Candidate k replaces the running best when:
  - valid[k] = 1 and found = 0 (first eligible candidate), or
  - valid[k] = 1 and ene[k] <= best_ene.
  - On replacement, set found = 1 and load best_ene, best_plot and best_idx = k.
- Comparison is unsigned, EW bits, with no saturation or offset.
- Ties resolve to the higher index, because the comparison is <=.
- After k = N-1 is processed, go to DONE.
- DONE:
  - Assert done for exactly one cycle.
  - Drive outene, outplot, outidx and found from the best registers, then go to IDLE.
  - Result outputs hold until the next accepted start clears them.
- If no candidate is eligible, found = 0 and outene, outplot and outidx are all 0.
- A start received in SCAN or DONE is ignored; it is neither queued nor restarted.
- Energy value all-ones is a normal value, not a sentinel. A valid candidate with energy 2^EW-1 can win.

## Timing
- Reset (p_reset = 1 at a clock edge):
  - State goes to IDLE and the counter to 0.
  - busy = 0, done = 0, found = 0, outene = 0, outplot = 0, outidx = 0.
  - Reset overrides start in the same cycle.
- Reset during SCAN or DONE aborts the operation: no done pulse and outputs zeroed.
- Latency: start sampled at edge t → done = 1 in the cycle after edge t+N+1, i.e. N+2 cycles from start to done.
- busy rises the cycle after start is accepted and falls together with done.
- Back-to-back use: a new start is accepted in the first IDLE cycle after DONE. Issue interval is N+2 cycles.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Basic minimum: N=4, ene = {40, 12, 30, 25}, plot = {1, 2, 4, 8}, valid = 4'b1111, start pulse → done after N+2 cycles with outene = 12, outplot = 2, outidx = 1, found = 1; busy high for N+1 cycles.
- Masking and tie: ene = {5, 9, 9, 3}, valid = 4'b0111 (candidate 3 blocked) → outene = 5, outidx = 0. Then ene = {7, 9, 7, 9}, all valid → outidx = 2, the higher-index tie winner.
- All blocked: valid = 0 with arbitrary energies → done pulse with found = 0, outene = 0, outplot = 0, outidx = 0.
- Extremes: ene = {1023, 1023, 1023, 1023}, only valid[2] = 1 → outene = 1023, outidx = 2, found = 1.
- Handshake robustness:
  - Hold start high continuously → exactly one selection every N+2 cycles.
  - Change in_ene during SCAN → result reflects the values captured at start.
- Reset mid-scan: assert p_reset two cycles into SCAN → next cycle busy = 0, outputs = 0, no done pulse; a subsequent start produces a correct result.
